mer_meas_ctrl: RTL and testbench

- Sequences the MER measurement datapath: reference-level calibration, error-accumulator clear/run, and result capture.
- Sits beside the MER device, 4-ASK slicer and error generators. It replaces free-running LFSR-cycle hold strobes with a deterministic, restartable measurement window.
- Latches squared and DC error sums once per window and pulses a valid flag for display/SignalTap.

---
 rtl/mer_meas_ctrl_pkg.sv | 27 ++
 rtl/mer_meas_ctrl_sym_window_cnt.sv | 26 ++
 rtl/mer_meas_ctrl.sv | 119 +++++++++++
 tb/tb_mer_meas_ctrl.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/mer_meas_ctrl_pkg.sv
// Shared state encodings and default window constants for the MER measurement sequencer.
// Reused by top-level LED/debug decode of the state output.
package mer_meas_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_SETTLE  = 3'd1,
        ST_REF_CAL = 3'd2,
        ST_ACCUM   = 3'd3,
        ST_DONE    = 3'd4
    } meas_state_e;

    localparam int DEF_SETTLE_SYMS = 64;
    localparam int DEF_CAL_LOG2    = 10;
    localparam int DEF_ACC_LOG2    = 16;
    localparam int DEF_ERR_W       = 18;
    localparam int DEF_CNT_W       = 16;

    // Width of the shared phase counter: wide enough for the longest phase, never 0.
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        m = (m > c) ? m : c;
        return (m < 1) ? 1 : m;
    endfunction

endpackage

// File: rtl/mer_meas_ctrl_sym_window_cnt.sv
// Loadable terminal-count symbol counter shared by the settle, ref-cal and accumulate phases.
// done fires combinationally on the sym_en that completes the window; the count then restarts at 0.
module mer_meas_ctrl_sym_window_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         en,
    input  logic         sym_en,
    input  logic [W-1:0] term,
    output logic         done
);
    logic [W-1:0] cnt;

    assign done = en & sym_en & (cnt == term);

    // Held at zero whenever no phase is running, so a new phase always starts from a clean count.
    always_ff @(posedge clk) begin
        if (reset || clear || !en)
            cnt <= '0;
        else if (sym_en)
            cnt <= done ? '0 : cnt + 1'b1;
    end

endmodule

// File: rtl/mer_meas_ctrl.sv
// MER measurement window sequencer: settle, reference calibration, error accumulation, result capture.
// Optional: define MER_SYM_ERR_CNT_EN to count slicer errors over each accumulation window.
module mer_meas_ctrl
    import mer_meas_ctrl_pkg::*;
#(
    parameter int SETTLE_SYMS = DEF_SETTLE_SYMS,
    parameter int CAL_LOG2    = DEF_CAL_LOG2,
    parameter int ACC_LOG2    = DEF_ACC_LOG2,
    parameter int ERR_W       = DEF_ERR_W,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sym_en,
    input  logic             start,
    input  logic             continuous,
    input  logic             abort,
    input  logic             sym_err,
    input  logic [ERR_W-1:0] acc_sq_err,
    input  logic [ERR_W-1:0] acc_dc_err,
    output logic             ref_hold,
    output logic             acc_clear,
    output logic             acc_run,
    output logic             busy,
    output logic [2:0]       state,
    output logic             meas_valid,
    output logic [ERR_W-1:0] sq_err_lat,
    output logic [ERR_W-1:0] dc_err_lat,
    output logic [CNT_W-1:0] meas_count,
    output logic [31:0]      sym_err_cnt
);
    localparam int PH_W = max3(CAL_LOG2, ACC_LOG2, $clog2(SETTLE_SYMS));
    localparam logic [PH_W-1:0] SETTLE_TERM = PH_W'(SETTLE_SYMS - 1);
    localparam logic [PH_W-1:0] CAL_TERM    = PH_W'((64'd1 << CAL_LOG2) - 64'd1);
    localparam logic [PH_W-1:0] ACC_TERM    = PH_W'((64'd1 << ACC_LOG2) - 64'd1);

    meas_state_e     cur, nxt;
    logic [PH_W-1:0] ph_term;
    logic            phase_en, ph_done, capture;

    assign state    = cur;
    assign phase_en = cur inside {ST_SETTLE, ST_REF_CAL, ST_ACCUM};
    assign capture  = (cur == ST_DONE) && !abort;

    mer_meas_ctrl_sym_window_cnt #(.W(PH_W)) u_win (
        .clk    (clk),
        .reset  (reset),
        .clear  (abort),
        .en     (phase_en),
        .sym_en (sym_en),
        .term   (ph_term),
        .done   (ph_done)
    );

    always_comb begin
        nxt     = cur;
        ph_term = '0;
        unique case (cur)
            ST_IDLE:    if (start) nxt = ST_SETTLE;
            ST_SETTLE:  begin ph_term = SETTLE_TERM; if (ph_done) nxt = ST_REF_CAL; end
            ST_REF_CAL: begin ph_term = CAL_TERM;    if (ph_done) nxt = ST_ACCUM;   end
            ST_ACCUM:   begin ph_term = ACC_TERM;    if (ph_done) nxt = ST_DONE;    end
            ST_DONE:    nxt = continuous ? ST_SETTLE : ST_IDLE;
            default:    nxt = ST_IDLE;
        endcase
        if (abort) nxt = ST_IDLE;
    end

    // Control outputs are registered from the next state so they change together with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            cur        <= ST_IDLE;
            acc_clear  <= 1'b1;
            acc_run    <= 1'b0;
            ref_hold   <= 1'b0;
            busy       <= 1'b0;
            meas_valid <= 1'b0;
            sq_err_lat <= '0;
            dc_err_lat <= '0;
            meas_count <= '0;
        end else begin
            cur        <= nxt;
            acc_clear  <= nxt inside {ST_IDLE, ST_SETTLE, ST_REF_CAL};
            acc_run    <= (nxt == ST_ACCUM);
            ref_hold   <= nxt inside {ST_ACCUM, ST_DONE};
            busy       <= (nxt != ST_IDLE);
            meas_valid <= capture;
            if (capture) begin
                sq_err_lat <= acc_sq_err;
                dc_err_lat <= acc_dc_err;
                meas_count <= meas_count + 1'b1;
            end
        end
    end

`ifdef MER_SYM_ERR_CNT_EN
    logic [31:0] err_win;

    // Window count restarts as ACCUM is entered; the entering sym_en belongs to REF_CAL.
    always_ff @(posedge clk) begin
        if (reset) begin
            err_win     <= '0;
            sym_err_cnt <= '0;
        end else begin
            if (cur == ST_REF_CAL && ph_done)
                err_win <= '0;
            else if (cur == ST_ACCUM && sym_en && sym_err && err_win != 32'hFFFF_FFFF)
                err_win <= err_win + 32'd1;
            if (capture)
                sym_err_cnt <= err_win;
        end
    end
`else
    logic unused_sym_err;
    assign unused_sym_err = sym_err;
    assign sym_err_cnt    = '0;
`endif

endmodule

// File: tb/tb_mer_meas_ctrl.sv
// Randomized bench for mer_meas_ctrl against a window-position reference model.
// Honours MER_SYM_ERR_CNT_EN when deciding the expected sym_err_cnt.
module tb_mer_meas_ctrl;
    localparam int SS  = 4;
    localparam int CL  = 2;
    localparam int AL  = 3;
    localparam int EW  = 18;
    localparam int CW  = 2;
    localparam int NC  = 1 << CL;
    localparam int NA  = 1 << AL;
    localparam int TOT = SS + NC + NA;

    logic          clk = 1'b0;
    logic          reset, sym_en, start, continuous, abort, sym_err;
    logic [EW-1:0] acc_sq_err, acc_dc_err;
    logic          ref_hold, acc_clear, acc_run, busy, meas_valid;
    logic [2:0]    state;
    logic [EW-1:0] sq_err_lat, dc_err_lat;
    logic [CW-1:0] meas_count;
    logic [31:0]   sym_err_cnt;

    mer_meas_ctrl #(
        .SETTLE_SYMS(SS), .CAL_LOG2(CL), .ACC_LOG2(AL), .ERR_W(EW), .CNT_W(CW)
    ) dut (
        .clk(clk), .reset(reset), .sym_en(sym_en), .start(start), .continuous(continuous),
        .abort(abort), .sym_err(sym_err), .acc_sq_err(acc_sq_err), .acc_dc_err(acc_dc_err),
        .ref_hold(ref_hold), .acc_clear(acc_clear), .acc_run(acc_run), .busy(busy),
        .state(state), .meas_valid(meas_valid), .sq_err_lat(sq_err_lat),
        .dc_err_lat(dc_err_lat), .meas_count(meas_count), .sym_err_cnt(sym_err_cnt)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    endtask

    // Reference model: mode 0 idle, 1 running (m_k symbols counted into the window), 2 done.
    int            m_mode = 0, m_k = 0, e_cnt = 0;
    logic [EW-1:0] e_sq = '0, e_dc = '0;
    logic [31:0]   e_win = '0, e_errc = '0;
    bit            e_valid = 0;

    task automatic model_step();
        e_valid = 0;
        if (reset) begin
            m_mode = 0; m_k = 0; e_cnt = 0; e_sq = '0; e_dc = '0; e_win = '0; e_errc = '0;
        end else if (abort) begin
            m_mode = 0;
        end else if (m_mode == 0) begin
            if (start) begin m_mode = 1; m_k = 0; end
        end else if (m_mode == 2) begin
            e_sq = acc_sq_err; e_dc = acc_dc_err;
            e_cnt = (e_cnt + 1) % (1 << CW);
            e_errc = e_win; e_valid = 1;
            if (continuous) begin m_mode = 1; m_k = 0; end
            else m_mode = 0;
        end else if (sym_en) begin
            if (m_k >= SS + NC && sym_err && e_win != 32'hFFFF_FFFF) e_win = e_win + 1;
            m_k++;
            if (m_k == SS + NC) e_win = '0;
            if (m_k == TOT) m_mode = 2;
        end
    endtask

    function automatic int exp_state();
        if (m_mode == 0) return 0;
        if (m_mode == 2) return 4;
        return (m_k < SS) ? 1 : (m_k < SS + NC) ? 2 : 3;
    endfunction

    task automatic compare_all();
        int es;
        logic [31:0] exp_errc;
        es = exp_state();
`ifdef MER_SYM_ERR_CNT_EN
        exp_errc = e_errc;
`else
        exp_errc = '0;
`endif
        chk("state", state, es);
        chk("busy", busy, m_mode != 0);
        chk("acc_clear", acc_clear, es < 3);
        chk("acc_run", acc_run, es == 3);
        chk("ref_hold", ref_hold, es >= 3);
        chk("meas_valid", meas_valid, e_valid);
        chk("sq_err_lat", sq_err_lat, e_sq);
        chk("dc_err_lat", dc_err_lat, e_dc);
        chk("meas_count", meas_count, e_cnt);
        chk("sym_err_cnt", sym_err_cnt, exp_errc);
    endtask

    int per = 8, cyc = 0, n_valid = 0, gap = -1;
    bit hold_acc = 0, err_dir = 0, gap_chk = 0;

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        compare_all();
        if (gap >= 0 && sym_en) gap++;
        if (meas_valid) begin
            n_valid++;
            if (gap_chk && gap >= 0) chk("valid_gap", gap, TOT);
            gap = 0;
        end
        cyc++;
        sym_en = (per != 0) ? (cyc % per == 0) : ($urandom_range(0, 2) == 0);
        if (!hold_acc) begin
            acc_sq_err = EW'($urandom);
            acc_dc_err = EW'($urandom);
        end
        if (err_dir)
            sym_err = (m_mode == 1) && (m_k == SS || m_k == SS + 1 || m_k == SS + NC + 1 ||
                                        m_k == SS + NC + 4 || m_k == SS + NC + 6);
        else
            sym_err = $urandom_range(0, 1) == 1;
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int i = 0;
        while (busy && i < budget) begin tick(); i++; end
        chk(tag, busy, 0);
    endtask

    task automatic wait_k(input string tag, input int k, input int budget);
        int i = 0;
        while (!(m_mode == 1 && m_k == k) && i < budget) begin tick(); i++; end
        chk(tag, state, (k < SS) ? 1 : (k < SS + NC) ? 2 : 3);
    endtask

    task automatic pulse_start();
        start = 1; tick(); start = 0;
    endtask

    initial begin
        logic [EW-1:0] sv_sq;
        int sv_cnt, base;
        reset = 1; start = 0; continuous = 0; abort = 0; sym_en = 0; sym_err = 0;
        acc_sq_err = '0; acc_dc_err = '0;
        repeat (3) tick();
        reset = 0;
        tick();
        chk("rst_acc_clear", acc_clear, 1);
        chk("rst_count", meas_count, 0);

        // single window with fixed accumulator values
        hold_acc = 1; acc_sq_err = 18'h00123; acc_dc_err = 18'h3FFF0;
        pulse_start();
        wait_idle("w1_done", 400);
        chk("w1_count", meas_count, 1);
        chk("w1_sq", sq_err_lat, 18'h00123);
        chk("w1_dc", dc_err_lat, 18'h3FFF0);
        hold_acc = 0;

        // three back-to-back windows
        continuous = 1; gap_chk = 1; gap = -1; base = n_valid;
        pulse_start();
        for (int i = 0; i < 1500 && n_valid - base < 3; i++) tick();
        chk("cont_windows", n_valid - base, 3);
        continuous = 0; gap_chk = 0;
        wait_idle("cont_idle", 400);

        // abort on the 5th accumulation symbol
        pulse_start();
        wait_k("abort_at", SS + NC + 4, 400);
        sv_sq = e_sq; sv_cnt = e_cnt;
        abort = 1; tick(); abort = 0;
        chk("abort_state", state, 0);
        chk("abort_cnt", meas_count, sv_cnt);
        chk("abort_sq", sq_err_lat, sv_sq);
        repeat (20) tick();

        // reset in the middle of reference calibration
        pulse_start();
        wait_k("rst_at", SS + 1, 400);
        reset = 1; tick(); reset = 0;
        chk("midrst_state", state, 0);
        chk("midrst_clear", acc_clear, 1);
        chk("midrst_sq", sq_err_lat, 0);

        // directed slicer errors: 2 in REF_CAL, 3 in ACCUM
        err_dir = 1;
        pulse_start();
        wait_idle("err_done", 400);
`ifdef MER_SYM_ERR_CNT_EN
        chk("err_window", sym_err_cnt, 3);
`else
        chk("err_window", sym_err_cnt, 0);
`endif
        err_dir = 0;

        // held start: back-to-back windows with count wrap
        reset = 1; tick(); reset = 0;
        per = 2; start = 1; base = n_valid;
        for (int i = 0; i < 2000 && n_valid - base < 4; i++) tick();
        chk("wrap_valids", n_valid - base, 4);
        chk("wrap_count", meas_count, 0);
        start = 0;
        wait_idle("wrap_idle", 200);

        // random traffic
        per = 0;
        for (int i = 0; i < 4000; i++) begin
            start = ($urandom_range(0, 19) == 0);
            abort = ($urandom_range(0, 199) == 0);
            reset = ($urandom_range(0, 999) == 0);
            if ($urandom_range(0, 49) == 0) continuous = ~continuous;
            tick();
        end
        start = 0; abort = 0; reset = 0; continuous = 0;
        wait_idle("rand_idle", 400);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
